dcache: RTL
===========

Name: dcache

Overview:
- Direct-mapped, write-back L1 data cache: the responder end of the datapath's data-memory request port (dmemREN/dmemWEN/dmemaddr/dmemstore → dhit/dmemload).
- Serves loads and stores from the pipeline's MEM stage and talks to the memory controller via a simple blocking dREN/dWEN/dwait port.
- On datapath halt, writes back every dirty frame, then stores the hit count to a fixed address and asserts flushed.

Parameters:
NSETS, 16, number of one-word frames (power of two, ≥2)
HIT_CNT_ADDR, 32'h00003100, byte address receiving the final hit count

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
halt  in  1  datapath halt request
dmemREN  in  1  load request
dmemWEN  in  1  store request
dmemaddr  in  32  request byte address
dmemstore  in  32  store data
dhit  out  1  request satisfied this cycle
dmemload  out  32  load data, valid when dhit && dmemREN
flushed  out  1  flush + count write complete
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address, [1:0]=0
dstore  out  32  memory write data
dwait  in  1  memory busy; transfer completes in a cycle with dwait=0
dload  in  32  memory read data, valid when dREN && !dwait

Behaviour:
- Address split: [1:0] ignored; index = [2+log2(NSETS)-1:2]; tag = remaining upper bits.
- Reset (async, immediate): all valid/dirty=0, state IDLE, hit count 0, filled=0. All outputs 0.
- States: IDLE, WB, FETCH, FLUSH, COUNT, HALTED.
- IDLE, halt=1 → FLUSH. halt has priority over any request; it is sampled only in IDLE.
- IDLE, request, hit (valid && tag match): dhit=1 combinationally in the same cycle.
  - Load: dmemload = frame data.
  - Store: frame data ← dmemstore and dirty ← 1 at the clock edge.
  - Hit count +1, unless filled=1 (hit immediately following a refill).
- dmemREN && dmemWEN together: treated as a store.
- IDLE, request, miss: dhit=0.
  - Victim valid && dirty → WB.
  - Otherwise → FETCH.
- WB: dWEN=1, daddr={victim tag, index, 2'b00}, dstore=victim data.
  - On !dwait: dirty ← 0, then → FETCH.
- FETCH: dREN=1, daddr={dmemaddr[31:2], 2'b00}.
  - On !dwait: data ← dload, tag written, valid ← 1, dirty ← 0, filled ← 1, then → IDLE.
  - The next IDLE cycle hits (uncounted) and then clears filled.
- dhit=0 in every state except IDLE. Memory-side outputs are 0 in IDLE and HALTED.
- Hit count: 32-bit, wraps modulo 2^32.
- FLUSH: index counter i from 0 up to NSETS-1.
  - Frame i valid && dirty: dWEN=1, daddr={tag, i, 2'b00}, dstore=data. On !dwait: clear dirty and advance i.
  - Otherwise: advance i after one cycle.
  - After frame NSETS-1 is handled → COUNT.
- COUNT: dWEN=1, daddr=HIT_CNT_ADDR, dstore=hit count. On !dwait → HALTED.
- HALTED: flushed=1. Terminal state until RST.
- Reset mid-WB/FETCH/FLUSH: aborts the transfer. dREN/dWEN drop asynchronously. Contents are invalidated; no partial write survives.
- dwait held high indefinitely: remain in the current state with request outputs stable.

Decomposition:
- Shared package (dcache_pkg):
  - dcache_state_t enum of the six states.
  - dcachef_t packed struct {tag, idx, bytoff}, sized from NSETS.
  - dframe_t struct {valid, dirty, tag, data}.
  - Default HIT_CNT_ADDR constant.
- One natural sub-module: dcache_frames, the frame array with async read by index, sync write, and async clear on RST. The FSM, counters and output muxing stay in dcache.

Test Plan:
- Cold load 0x40 → FETCH, dREN=1, daddr=0x40. dwait low after 3 cycles with dload=0xDEADBEEF → next cycle dhit=1, dmemload=0xDEADBEEF, hit count stays 0.
- Store 0x40 ← 0x12345678 after fill → same-cycle dhit=1. Following load 0x40 returns 0x12345678. Hit count=2.
- Dirty conflict: load 0x80 (same index 0, tag 2) → WB with daddr=0x40, dstore=0x12345678, then FETCH daddr=0x80. No dhit until the fill completes.
- Halt with dirty frames 0 and 5 → exactly two write-backs, in ascending index order. Then write daddr=0x3100 with dstore=current hit count. flushed=1 and remains high.
- RST asserted mid-WB with dwait=1 → dWEN falls immediately. After release, load 0x40 misses (no valid frames). Hit count reads 0.
- dmemREN and dmemWEN both high on a hit → store performed, dirty set, dhit=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and defaults for the direct-mapped write-back data cache
package dcache_pkg;
    localparam int DEF_NSETS = 16;
    localparam int DEF_IDX_W = $clog2(DEF_NSETS);
    localparam int DEF_TAG_W = 30 - DEF_IDX_W;
    localparam logic [31:0] DEF_HIT_CNT_ADDR = 32'h00003100;
    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, COUNT, HALTED} dcache_state_t;
    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_IDX_W-1:0] idx;
        logic [1:0]           bytoff;
    } dcachef_t;
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [DEF_TAG_W-1:0] tag;
        logic [31:0]          data;
    } dframe_t;
endpackage

// File: rtl/dcache_if.sv
// dcache_if: datapath request port plus memory-controller port of the data cache
interface dcache_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_frames.sv
// dcache_frames: one-word frame array, async read by index, sync write, async invalidate
module dcache_frames #(
    parameter int NSETS = 16,
    parameter int TW    = 26,
    localparam int IW   = $clog2(NSETS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] idx,
    output logic          valid,
    output logic          dirty,
    output logic [TW-1:0] tag,
    output logic [31:0]   data,
    input  logic          we,
    input  logic          wvalid,
    input  logic          wdirty,
    input  logic [TW-1:0] wtag,
    input  logic [31:0]   wdata
);
    logic [NSETS-1:0] valid_q;
    logic [NSETS-1:0] dirty_q;
    logic [TW-1:0]    tag_q  [NSETS];
    logic [31:0]      data_q [NSETS];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign data  = data_q[idx];

    // state flags clear at once on reset so no stale or partially written frame survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[idx] <= wvalid;
            dirty_q[idx] <= wdirty;
        end
    end

    // tag and data carry no reset; they are meaningless while the frame is invalid
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= wtag;
            data_q[idx] <= wdata;
        end
    end
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back L1 data cache with halt-time flush and hit-count dump
module dcache import dcache_pkg::*; #(
    parameter int          NSETS        = DEF_NSETS,
    parameter logic [31:0] HIT_CNT_ADDR = DEF_HIT_CNT_ADDR
) (
    input logic     CLK,
    input logic     RST,
    dcache_if.slave bus
);
    localparam int IW = $clog2(NSETS);
    localparam int TW = 30 - IW;

    dcache_state_t state, next;
    logic [IW-1:0] fidx, ridx, idx;
    logic [TW-1:0] rtag, f_tag, wtag;
    logic [31:0]   hits, f_data, wdata;
    logic          filled, req, hit, wb_need, f_valid, f_dirty, we, wvalid, wdirty;

    assign ridx    = bus.dmemaddr[IW+1:2];
    assign rtag    = bus.dmemaddr[31:IW+2];
    assign idx     = state == FLUSH ? fidx : ridx;
    assign req     = bus.dmemREN | bus.dmemWEN;
    assign hit     = state == IDLE && !bus.halt && req && f_valid && f_tag == rtag;
    assign wb_need = f_valid && f_dirty;

    dcache_frames #(.NSETS(NSETS), .TW(TW)) frames (
        .clk(CLK), .rst(RST), .idx(idx),
        .valid(f_valid), .dirty(f_dirty), .tag(f_tag), .data(f_data),
        .we(we), .wvalid(wvalid), .wdirty(wdirty), .wtag(wtag), .wdata(wdata)
    );

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    // next state: halt wins in IDLE, every transfer waits for a cycle with dwait low
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.halt ? FLUSH : (req && !hit ? (wb_need ? WB : FETCH) : IDLE);
            WB:      next = bus.dwait ? WB : FETCH;
            FETCH:   next = bus.dwait ? FETCH : IDLE;
            FLUSH:   next = &fidx && (!wb_need || !bus.dwait) ? COUNT : FLUSH;
            COUNT:   next = bus.dwait ? COUNT : HALTED;
            default: next = state;
        endcase
    end

    // outputs and frame updates; a write always stores the whole frame back at idx
    always_comb begin
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        bus.flushed  = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        we           = 1'b0;
        wvalid       = 1'b1;
        wdirty       = 1'b0;
        wtag         = f_tag;
        wdata        = f_data;
        case (state)
            IDLE: begin
                bus.dhit     = hit;
                bus.dmemload = hit ? f_data : '0;
                we           = hit && bus.dmemWEN;
                wdirty       = 1'b1;
                wdata        = bus.dmemstore;
            end
            WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {f_tag, ridx, 2'b00};
                bus.dstore = f_data;
                we         = !bus.dwait;
            end
            FETCH: begin
                bus.dREN  = 1'b1;
                bus.daddr = {bus.dmemaddr[31:2], 2'b00};
                we        = !bus.dwait;
                wtag      = rtag;
                wdata     = bus.dload;
            end
            FLUSH: begin
                bus.dWEN   = wb_need;
                bus.daddr  = wb_need ? {f_tag, fidx, 2'b00} : '0;
                bus.dstore = wb_need ? f_data : '0;
                we         = wb_need && !bus.dwait;
            end
            COUNT: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = HIT_CNT_ADDR;
                bus.dstore = hits;
            end
            HALTED:  bus.flushed = 1'b1;
            default: bus.flushed = 1'b0;
        endcase
    end

    // hit counter (refill-induced hits skipped), refill marker and flush index
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hits   <= '0;
            filled <= 1'b0;
            fidx   <= '0;
        end else begin
            if (hit && !filled) hits <= hits + 32'd1;
            filled <= (state == FETCH && !bus.dwait) || (filled && state != IDLE);
            if (state == FLUSH && (!wb_need || !bus.dwait)) fidx <= fidx + 1'b1;
        end
    end
endmodule
